// File: rtl/hilo_mult_sequencer_pkg.sv
// Shared types and constants for the HI/LO multiply sequencer.
package hilo_mult_sequencer_pkg;

    typedef enum logic [1:0] {
        MS_IDLE,
        MS_RUN,
        MS_FIX
    } mult_state_t;

    localparam logic [1:0] REGSEL_MFHI = 2'd1;
    localparam logic [1:0] REGSEL_MFLO = 2'd2;

    localparam int unsigned DATA_W = 32;

endpackage

// File: rtl/mult_shift_add_dp.sv
// Shift-add multiplier datapath: operand magnitudes, accumulator and final sign fix-up.
module mult_shift_add_dp #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 step,
    input  logic                 signed_op,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [CNT_W-1:0]     cnt,
    output logic [2*WIDTH-1:0]   product,
    output logic                 mplier_rest_zero
);

    logic [WIDTH-1:0]   mcand_q, mplier_q;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic               neg_q;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [2*WIDTH-1:0] addend;

    // -2**(WIDTH-1) negates to itself, which reads correctly as an unsigned magnitude.
    always_comb begin
        a_mag = (signed_op && a[WIDTH-1]) ? -a : a;
        b_mag = (signed_op && b[WIDTH-1]) ? -b : b;
    end

    always_comb begin
        addend = {{WIDTH{1'b0}}, mcand_q} << cnt;
        acc_d  = mplier_q[0] ? (acc_q + addend) : acc_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            neg_q    <= 1'b0;
        end else if (load) begin
            mcand_q  <= a_mag;
            mplier_q <= b_mag;
            acc_q    <= '0;
            neg_q    <= signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
        end else if (step) begin
            mplier_q <= mplier_q >> 1;
            acc_q    <= acc_d;
        end
    end

    assign product          = neg_q ? -acc_q : acc_q;
    assign mplier_rest_zero = (mplier_q[WIDTH-1:1] == '0);

endmodule

// File: rtl/hilo_mult_sequencer.sv
// Multi-cycle mult/multu sequencer owning HI/LO, with fetch stall while busy.
// Optional early termination on exhausted multiplier: define MULT_EARLY_TERM_EN.
module hilo_mult_sequencer
    import hilo_mult_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH = DATA_W,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enhilo_EX,
    input  logic             signed_EX,
    input  logic [WIDTH-1:0] a_EX,
    input  logic [WIDTH-1:0] b_EX,
    input  logic [1:0]       regsel_EX,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             stall_FETCH
);

`ifdef MULT_EARLY_TERM_EN
    localparam bit EarlyTerm = 1'b1;
`else
    localparam bit EarlyTerm = 1'b0;
`endif

    localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WIDTH - 1);

    mult_state_t        state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic               done_q;
    logic               load, step, fix;
    logic [2*WIDTH-1:0] product;
    logic               mplier_rest_zero;
    logic               b_zero;

    // |b| is zero exactly when b is zero, signed or not.
    assign b_zero = (b_EX == '0);

    mult_shift_add_dp #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_dp (
        .clk              (clk),
        .rst              (rst),
        .load             (load),
        .step             (step),
        .signed_op        (signed_EX),
        .a                (a_EX),
        .b                (b_EX),
        .cnt              (cnt_q),
        .product          (product),
        .mplier_rest_zero (mplier_rest_zero)
    );

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        fix     = 1'b0;
        unique case (state_q)
            MS_IDLE: begin
                if (enhilo_EX) begin
                    load    = 1'b1;
                    state_d = (EarlyTerm && b_zero) ? MS_FIX : MS_RUN;
                end
            end
            MS_RUN: begin
                step = 1'b1;
                if (cnt_q == LastCnt || (EarlyTerm && mplier_rest_zero)) begin
                    state_d = MS_FIX;
                end
            end
            MS_FIX: begin
                fix     = 1'b1;
                state_d = MS_IDLE;
            end
            default: state_d = MS_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= MS_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= fix;
            if (load) begin
                cnt_q <= '0;
            end else if (step) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (fix) begin
                {hi_q, lo_q} <= product;
            end
        end
    end

    assign hi          = hi_q;
    assign lo          = lo_q;
    assign done        = done_q;
    assign busy        = (state_q != MS_IDLE);
    assign stall_FETCH = busy & (enhilo_EX | (regsel_EX != 2'd0));

endmodule

// File: tb/tb_hilo_mult_sequencer.sv
// Self-checking bench for hilo_mult_sequencer; honours MULT_EARLY_TERM_EN for latency expectations.
module tb_hilo_mult_sequencer;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         enhilo_EX, signed_EX;
    logic [W-1:0] a_EX, b_EX;
    logic [1:0]   regsel_EX;
    logic [W-1:0] hi, lo;
    logic         busy, done, stall_FETCH;

    int checks = 0;
    int failures = 0;
    logic [2*W-1:0] exp_q[$];

    hilo_mult_sequencer #(
        .WIDTH (W),
        .CNT_W (6)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enhilo_EX   (enhilo_EX),
        .signed_EX   (signed_EX),
        .a_EX        (a_EX),
        .b_EX        (b_EX),
        .regsel_EX   (regsel_EX),
        .hi          (hi),
        .lo          (lo),
        .busy        (busy),
        .done        (done),
        .stall_FETCH (stall_FETCH)
    );

    always #5 clk = ~clk;

    function automatic logic [2*W-1:0] model(input logic s, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        logic signed [2*W-1:0] sa, sb;
        if (s) begin
            sa = {{W{a[W-1]}}, a};
            sb = {{W{b[W-1]}}, b};
            return sa * sb;
        end
        return {{W{1'b0}}, a} * {{W{1'b0}}, b};
    endfunction

    function automatic int exp_latency(input logic s, input logic [W-1:0] b);
        logic [W-1:0] m;
        m = (s && b[W-1]) ? -b : b;
`ifdef MULT_EARLY_TERM_EN
        if (m == '0) return 1;
        for (int i = W - 1; i >= 0; i--) begin
            if (m[i]) return i + 2;
        end
        return 1;
`else
        return W + 1;
`endif
    endfunction

    // Drives a start for one cycle and records the expected product.
    task automatic issue(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        enhilo_EX = 1'b1;
        signed_EX = s;
        a_EX      = a;
        b_EX      = b;
        exp_q.push_back(model(s, a, b));
        @(posedge clk);
        #1 enhilo_EX = 1'b0;
    endtask

    // Counts edges after the start edge until done is seen; -1 on timeout.
    task automatic wait_done(input string name, output int n);
        n = 0;
        while (n <= 200) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (done === 1'b1) break;
        end
        if (done !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: done=%b required=1 within 200 cycles", name, done);
            n = -1;
        end
    endtask

    task automatic test_reset();
        rst       = 1'b0;
        enhilo_EX = 1'b0;
        signed_EX = 1'b0;
        a_EX      = '0;
        b_EX      = '0;
        regsel_EX = 2'd2;
        #3;
        checks++;
        if ({hi, lo} !== '0) begin
            failures++;
            $display("FAIL reset_hilo: got=%h required=0", {hi, lo});
        end
        checks++;
        if ({busy, done, stall_FETCH} !== 3'b000) begin
            failures++;
            $display("FAIL reset_flags: busy/done/stall=%b required=000", {busy, done, stall_FETCH});
        end
        regsel_EX = 2'd0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_mult(input string name, input logic s, input logic [W-1:0] a,
                             input logic [W-1:0] b);
        int n, lat;
        logic [2*W-1:0] e;
        lat = exp_latency(s, b);
        issue(s, a, b);
        wait_done(name, n);
        e = exp_q.pop_front();
        checks++;
        if (n !== lat) begin
            failures++;
            $display("FAIL %s_latency: got=%0d required=%0d", name, n, lat);
        end
        checks++;
        if ({hi, lo} !== e) begin
            failures++;
            $display("FAIL %s_product: got=%h required=%h", name, {hi, lo}, e);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL %s_pulse: done/busy=%b%b required=00", name, done, busy);
        end
    endtask

    task automatic test_mflo_stall();
        int n;
        logic [2*W-1:0] e;
        issue(1'b0, 32'h1234_5678, 32'h9ABC_DEF1);
        e = exp_q.pop_front();
        @(posedge clk);
        @(posedge clk);
        #1 regsel_EX = 2'd2;
        n = 2;
        while (n < 200) begin
            @(negedge clk);
            if (busy !== 1'b1) break;
            checks++;
            if (stall_FETCH !== 1'b1) begin
                failures++;
                $display("FAIL mflo_stall_busy: cycle=%0d stall=%b required=1", n, stall_FETCH);
            end
            @(posedge clk);
            n++;
        end
        checks++;
        if (stall_FETCH !== 1'b0 || done !== 1'b1) begin
            failures++;
            $display("FAIL mflo_release: stall/done=%b%b required=01", stall_FETCH, done);
        end
        checks++;
        if (lo !== e[W-1:0] || hi !== e[2*W-1:W]) begin
            failures++;
            $display("FAIL mflo_value: got=%h required=%h", {hi, lo}, e);
        end
        regsel_EX = 2'd0;
    endtask

    task automatic test_back_to_back();
        int n, lat1, lat2;
        logic [2*W-1:0] e;
        lat1 = exp_latency(1'b0, 32'hF000_0001);
        lat2 = exp_latency(1'b1, 32'hFFFF_FFF9);
        @(negedge clk);
        enhilo_EX = 1'b1;
        signed_EX = 1'b0;
        a_EX      = 32'h0001_0003;
        b_EX      = 32'hF000_0001;
        exp_q.push_back(model(1'b0, 32'h0001_0003, 32'hF000_0001));
        @(posedge clk);
        #1;
        signed_EX = 1'b1;
        a_EX      = 32'h0000_0123;
        b_EX      = 32'hFFFF_FFF9;
        exp_q.push_back(model(1'b1, 32'h0000_0123, 32'hFFFF_FFF9));
        n = 0;
        while (n <= 200) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (done === 1'b1) break;
            checks++;
            if (stall_FETCH !== 1'b1) begin
                failures++;
                $display("FAIL b2b_stall: cycle=%0d stall=%b required=1", n, stall_FETCH);
            end
        end
        e = exp_q.pop_front();
        checks++;
        if (n !== lat1) begin
            failures++;
            $display("FAIL b2b_latency1: got=%0d required=%0d", n, lat1);
        end
        checks++;
        if ({hi, lo} !== e || stall_FETCH !== 1'b0) begin
            failures++;
            $display("FAIL b2b_first: got=%h stall=%b required=%h stall=0", {hi, lo},
                     stall_FETCH, e);
        end
        @(posedge clk);
        #1 enhilo_EX = 1'b0;
        wait_done("b2b_second", n);
        e = exp_q.pop_front();
        checks++;
        if (n !== lat2) begin
            failures++;
            $display("FAIL b2b_latency2: got=%0d required=%0d", n, lat2);
        end
        checks++;
        if ({hi, lo} !== e) begin
            failures++;
            $display("FAIL b2b_second: got=%h required=%h", {hi, lo}, e);
        end
    endtask

    task automatic test_reset_mid();
        issue(1'b1, 32'hDEAD_BEEF, 32'h1357_9BDF);
        void'(exp_q.pop_back());
        repeat (10) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({hi, lo} !== '0 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL midreset_async: hilo=%h busy=%b done=%b required=0/0/0", {hi, lo},
                     busy, done);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL midreset_hold: cycle=%0d done/busy=%b%b required=00", i, done,
                         busy);
            end
        end
        rst = 1'b1;
        test_mult("after_reset", 1'b0, 32'h0000_0011, 32'h0000_0101);
    endtask

    initial begin
        test_reset();
        test_mult("multu_3x5", 1'b0, 32'd3, 32'd5);
        test_mult("mult_neg1x2", 1'b1, 32'hFFFF_FFFF, 32'd2);
        test_mult("multu_max", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        test_mult("mult_min", 1'b1, 32'h8000_0000, 32'h8000_0000);
        test_mult("mult_negb", 1'b1, 32'd1000, 32'hFFFF_FC18);
        test_mflo_stall();
        test_back_to_back();
        test_reset_mid();
        test_mult("et_b1", 1'b0, 32'd7, 32'd1);
        test_mult("et_b0", 1'b0, 32'h55, 32'd0);
        for (int i = 0; i < 4; i++) begin
            test_mult("random", 1'($urandom_range(0, 1)), $urandom, $urandom);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
